adder_entry_sequencer: RTL and testbench

//  Front-end controller for the 4-bit signed adder display. Steps the user through

---
 rtl/adder_entry_sequencer_pkg.sv | 26 ++
 rtl/adder_entry_sequencer_if.sv | 32 +++
 rtl/adder_entry_sequencer_key_debounce.sv | 52 +++++
 rtl/adder_entry_sequencer.sv | 121 ++++++++++++
 tb/tb_adder_entry_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/adder_entry_sequencer_pkg.sv
// Shared definitions for the adder entry sequencer.
// Holds the FSM state type, the digit-enable patterns used while each
// display field is live, and the signed-overflow helper used by the adder.
package adder_entry_sequencer_pkg;

    // Encodings are visible on state_dbg, so the values are fixed.
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_ADD  = 2'd2,
        S_SHOW = 2'd3
    } seq_state_t;

    // digit_en patterns: bit5=HEX5 ... bit0=HEX0, 0 = blank.
    localparam logic [5:0] EN_A   = 6'b110000;
    localparam logic [5:0] EN_B   = 6'b111100;
    localparam logic [5:0] EN_ALL = 6'b111111;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [3:0] s);
        return (a[3] == b[3]) && (s[3] != a[3]);
    endfunction

endpackage

// File: rtl/adder_entry_sequencer_if.sv
// Display/entry bus of the adder entry sequencer.
//   sw_data    : operand entry switches (two's complement)
//   key_step_n : raw step push-button, active low
//   input1     : operand A to the HEX display driver
//   input2     : operand B to the HEX display driver
//   sum        : A+B, 4-bit wrap
//   overflow   : signed overflow of A+B
//   digit_en   : per-digit enable, bit5=HEX5 ... bit0=HEX0, 0 = blank
//   state_dbg  : current FSM state encoding
// master = sequencer side, slave = board/display side.
interface adder_entry_sequencer_if;

    logic [3:0] sw_data;
    logic       key_step_n;
    logic [3:0] input1;
    logic [3:0] input2;
    logic [3:0] sum;
    logic       overflow;
    logic [5:0] digit_en;
    logic [1:0] state_dbg;

    modport master (
        input  sw_data, key_step_n,
        output input1, input2, sum, overflow, digit_en, state_dbg
    );

    modport slave (
        output sw_data, key_step_n,
        input  input1, input2, sum, overflow, digit_en, state_dbg
    );

endinterface

// File: rtl/adder_entry_sequencer_key_debounce.sv
// Step-key conditioner: 2-flop synchronizer, level debounce, press pulse.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (key seen as released)
//   key_n  : raw active-low push-button, asynchronous and bouncy
//   press  : one-cycle pulse on an accepted released->pressed transition
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the current accepted level; latency from a clean
// edge to press is 2 + DEBOUNCE_CYCLES cycles.
module adder_entry_sequencer_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_s1;
    logic          key_s2;
    logic          key_db;
    logic [CW-1:0] cnt;
    logic          accept;

    // The final differing sample of the run flips the accepted level.
    assign accept = (key_s2 != key_db) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_db <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            press  <= accept && !key_s2;
            if (key_s2 == key_db) begin
                cnt <= '0;
            end else if (accept) begin
                cnt    <= '0;
                key_db <= key_s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_entry_sequencer.sv
// Front-end controller for the 4-bit signed adder display.
//   clk    : system clock, single domain
//   rst_n  : asynchronous active-low reset
//   bus    : entry/display bus (master side), see adder_entry_sequencer_if
// One key press per step: enter A (S_A), enter B (S_B), add for one cycle
// (S_ADD), then hold the result (S_SHOW). On overflow the two sum digits
// blink with a BLINK_DIV-cycle half-period, starting visible.
module adder_entry_sequencer
    import adder_entry_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder_entry_sequencer_if.master bus
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    seq_state_t    state, state_next;
    logic [3:0]    input1, input1_next;
    logic [3:0]    input2, input2_next;
    logic [3:0]    sum, sum_next;
    logic          ovf, ovf_next;
    logic [BW-1:0] blink_cnt, blink_cnt_next;
    logic          blink_on, blink_on_next;
    logic          press;
    logic [5:0]    digit_en;

    adder_entry_sequencer_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(bus.key_step_n),
        .press(press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            input1    <= '0;
            input2    <= '0;
            sum       <= '0;
            ovf       <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            state     <= state_next;
            input1    <= input1_next;
            input2    <= input2_next;
            sum       <= sum_next;
            ovf       <= ovf_next;
            blink_cnt <= blink_cnt_next;
            blink_on  <= blink_on_next;
        end
    end

    always_comb begin
        state_next     = state;
        input1_next    = input1;
        input2_next    = input2;
        sum_next       = sum;
        ovf_next       = ovf;
        blink_cnt_next = blink_cnt;
        blink_on_next  = blink_on;
        case (state)
            S_A: begin
                input1_next = bus.sw_data;
                if (press) state_next = S_B;
            end
            S_B: begin
                input2_next = bus.sw_data;
                if (press) state_next = S_ADD;
            end
            S_ADD: begin
                sum_next       = input1 + input2;
                ovf_next       = signed_ovf(input1, input2, sum_next);
                // Blink restarts visible on every SHOW entry.
                blink_cnt_next = '0;
                blink_on_next  = 1'b1;
                state_next     = S_SHOW;
            end
            S_SHOW: begin
                if (press) begin
                    state_next  = S_A;
                    input2_next = '0;
                    sum_next    = '0;
                    ovf_next    = 1'b0;
                end else if (blink_cnt == BLINK_LAST) begin
                    blink_cnt_next = '0;
                    blink_on_next  = !blink_on;
                end else begin
                    blink_cnt_next = blink_cnt + 1'b1;
                end
            end
            default: state_next = S_A;
        endcase
    end

    always_comb begin
        digit_en = EN_A;
        case (state)
            S_A:    digit_en = EN_A;
            S_B:    digit_en = EN_B;
            S_ADD:  digit_en = EN_B;
            S_SHOW: digit_en = (ovf && !blink_on) ? EN_B : EN_ALL;
            default: digit_en = EN_A;
        endcase
    end

    assign bus.input1    = input1;
    assign bus.input2    = input2;
    assign bus.sum       = sum;
    assign bus.overflow  = ovf;
    assign bus.digit_en  = digit_en;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_adder_entry_sequencer.sv
module tb_adder_entry_sequencer;

    typedef struct {
        logic [3:0] s;
        logic       ov;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    sb_item_t sbq[$];

    adder_entry_sequencer_if bif();

    adder_entry_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_DIV(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: add as signed integers, overflow if outside [-8,7].
    function automatic sb_item_t model(input logic [3:0] a, input logic [3:0] b);
        sb_item_t e;
        int r;
        r = int'($signed(a)) + int'($signed(b));
        e.s  = 4'(r);
        e.ov = (r > 7) || (r < -8);
        return e;
    endfunction

    // Drop the key and wait (bounded) for the state to move; key stays low.
    task automatic press_expect(input string tag, input logic [1:0] exp_state);
        logic [1:0] old;
        old = bif.state_dbg;
        bif.key_step_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.state_dbg != old) break;
        end
        chk(tag, {6'd0, bif.state_dbg}, {6'd0, exp_state});
    endtask

    task automatic release_key();
        bif.key_step_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic enter_and_add(input logic [3:0] a, input logic [3:0] b);
        sb_item_t e, got;
        bif.sw_data = a;
        repeat (2) @(negedge clk);
        chk("a_state", {6'd0, bif.state_dbg}, 8'd0);
        chk("a_input1", {4'd0, bif.input1}, {4'd0, a});
        chk("a_digit_en", {2'd0, bif.digit_en}, 8'b00110000);
        press_expect("to_s_b", 2'd1);
        release_key();
        bif.sw_data = b;
        repeat (2) @(negedge clk);
        chk("b_input1_frozen", {4'd0, bif.input1}, {4'd0, a});
        chk("b_input2", {4'd0, bif.input2}, {4'd0, b});
        chk("b_digit_en", {2'd0, bif.digit_en}, 8'b00111100);
        sbq.push_back(model(a, b));
        press_expect("to_s_add", 2'd2);
        @(negedge clk);
        chk("add_one_cycle", {6'd0, bif.state_dbg}, 8'd3);
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got = sbq.pop_front();
            chk("sum", {4'd0, bif.sum}, {4'd0, got.s});
            chk("overflow", {7'd0, bif.overflow}, {7'd0, got.ov});
            e = got;
            if (e.ov) begin
                // Key still held: no extra press may disturb the blink phase.
                for (int i = 0; i < 24; i++) begin
                    chk("blink", {2'd0, bif.digit_en},
                        (((i / 8) % 2) == 0) ? 8'b00111111 : 8'b00111100);
                    @(negedge clk);
                end
            end else begin
                chk("show_digit_en", {2'd0, bif.digit_en}, 8'b00111111);
            end
        end
        release_key();
        bif.sw_data = ~b;
        repeat (2) @(negedge clk);
        chk("show_hold_state", {6'd0, bif.state_dbg}, 8'd3);
        chk("show_hold_input1", {4'd0, bif.input1}, {4'd0, a});
        chk("show_hold_input2", {4'd0, bif.input2}, {4'd0, b});
    endtask

    task automatic leave_show(input logic [3:0] next_a);
        press_expect("to_s_a", 2'd0);
        chk("clr_input2", {4'd0, bif.input2}, 8'd0);
        chk("clr_sum", {4'd0, bif.sum}, 8'd0);
        chk("clr_overflow", {7'd0, bif.overflow}, 8'd0);
        bif.sw_data = next_a;
        @(negedge clk);
        chk("input1_tracks", {4'd0, bif.input1}, {4'd0, next_a});
        release_key();
    endtask

    initial begin
        int transitions;
        logic [1:0] prev;
        bif.sw_data    = 4'h0;
        bif.key_step_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state", {6'd0, bif.state_dbg}, 8'd0);
        chk("rst_digit_en", {2'd0, bif.digit_en}, 8'b00110000);
        chk("rst_sum", {3'd0, bif.sum, bif.overflow}, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        enter_and_add(4'h3, 4'h2);
        leave_show(4'h0);
        enter_and_add(4'h7, 4'h1);
        leave_show(4'h0);
        enter_and_add(4'h8, 4'hF);
        leave_show(4'h0);
        enter_and_add(4'hD, 4'h2);

        // Asynchronous reset in the middle of S_SHOW.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {6'd0, bif.state_dbg}, 8'd0);
        chk("mid_rst_digit_en", {2'd0, bif.digit_en}, 8'b00110000);
        chk("mid_rst_inputs", {bif.input1, bif.input2}, 8'd0);
        chk("mid_rst_sum", {3'd0, bif.sum, bif.overflow}, 8'd0);
        bif.sw_data = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Short glitch: shorter than the debounce window.
        bif.key_step_n = 1'b0;
        repeat (3) @(negedge clk);
        bif.key_step_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_no_step", {6'd0, bif.state_dbg}, 8'd0);

        // Long hold: exactly one step.
        transitions = 0;
        prev = bif.state_dbg;
        bif.key_step_n = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bif.state_dbg != prev) transitions++;
            prev = bif.state_dbg;
        end
        chk("hold_transitions", 8'(transitions), 8'd1);
        chk("hold_state", {6'd0, bif.state_dbg}, 8'd1);
        release_key();

        press_expect("late_to_s_add", 2'd2);
        @(negedge clk);
        chk("late_show", {6'd0, bif.state_dbg}, 8'd3);
        release_key();
        leave_show(4'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
